systolic_mac_array: RTL and testbench



---
 rtl/systolic_mac_array.sv | 208 ++++++++++++++++++++
 tb/tb_systolic_mac_array.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary MAC_WIDTH x MAC_WIDTH systolic array: skewed operands in, one C row per cycle out.
// Build option: define SIGNED_MAC_EN for two's-complement operands; the default build is unsigned.
module systolic_mac_array #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 8,
  parameter int ACC_SIZE  = 24,
  parameter int IDX_W     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_SIZE*MAC_WIDTH-1:0] left_in,
  input  logic [DATA_SIZE*MAC_WIDTH-1:0] top_in,
  output logic                           busy,
  output logic                           result_valid,
  output logic [ACC_SIZE*MAC_WIDTH-1:0]  result_row,
  output logic [IDX_W-1:0]               result_row_idx,
  output logic                           done
);

  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int ROW_W  = ACC_SIZE * MAC_WIDTH;
  localparam int CNT_W  = $clog2(3 * MAC_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COMPUTE = CNT_W'(3 * MAC_WIDTH - 2);
  localparam logic [CNT_W-1:0] DRAIN_END    = CNT_W'(MAC_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  function automatic logic [ACC_SIZE-1:0] mac_product(input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
`ifdef SIGNED_MAC_EN
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    logic signed [PROD_W-1:0] p;
    sa = {{DATA_SIZE{a[DATA_SIZE-1]}}, a};
    sb = {{DATA_SIZE{b[DATA_SIZE-1]}}, b};
    p  = sa * sb;
    return {{(ACC_SIZE-PROD_W){p[PROD_W-1]}}, p};
`else
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return {{(ACC_SIZE-PROD_W){1'b0}}, p};
`endif
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   clear_acc_s;
  logic                   compute_s;
  logic [ROW_W-1:0]       drain_row_s;

  // Pass-register outputs that feed a right or lower neighbour, plus every accumulator.
  logic [DATA_SIZE*MAC_WIDTH*(MAC_WIDTH-1)-1:0] a_flat_s;
  logic [DATA_SIZE*MAC_WIDTH*(MAC_WIDTH-1)-1:0] b_flat_s;
  logic [ACC_SIZE*MAC_WIDTH*MAC_WIDTH-1:0]      acc_flat_s;

  assign clear_acc_s = (state_q == ST_IDLE) && start;
  assign compute_s   = (state_q == ST_COMPUTE);

  for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_row
    for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_col
      logic [DATA_SIZE-1:0] a_src_s, b_src_s;
      logic [DATA_SIZE-1:0] a_d, a_q, b_d, b_q;
      logic [ACC_SIZE-1:0]  acc_d, acc_q;

      if (j == 0) begin : g_a_edge
        assign a_src_s = left_in[i*DATA_SIZE +: DATA_SIZE];
      end else begin : g_a_pass
        assign a_src_s = a_flat_s[(i*(MAC_WIDTH-1)+j-1)*DATA_SIZE +: DATA_SIZE];
      end
      if (i == 0) begin : g_b_edge
        assign b_src_s = top_in[j*DATA_SIZE +: DATA_SIZE];
      end else begin : g_b_pass
        assign b_src_s = b_flat_s[((i-1)*MAC_WIDTH+j)*DATA_SIZE +: DATA_SIZE];
      end
      if (j < MAC_WIDTH - 1) begin : g_a_out
        assign a_flat_s[(i*(MAC_WIDTH-1)+j)*DATA_SIZE +: DATA_SIZE] = a_q;
      end
      if (i < MAC_WIDTH - 1) begin : g_b_out
        assign b_flat_s[(i*MAC_WIDTH+j)*DATA_SIZE +: DATA_SIZE] = b_q;
      end
      assign acc_flat_s[(i*MAC_WIDTH+j)*ACC_SIZE +: ACC_SIZE] = acc_q;

      // PE next state: operands always shift, the accumulator only moves while computing.
      always_comb begin
        a_d = a_src_s;
        b_d = b_src_s;
        if (clear_acc_s) begin
          acc_d = '0;
        end else if (compute_s) begin
          acc_d = acc_q + mac_product(a_q, b_q);
        end else begin
          acc_d = acc_q;
        end
      end

      // PE registers.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end
    end
  end

  // Accumulator row addressed by the drain counter.
  always_comb begin
    drain_row_s = '0;
    for (int r = 0; r < MAC_WIDTH; r++) begin
      drain_row_s = (cnt_q == CNT_W'(r)) ? acc_flat_s[r*ROW_W +: ROW_W] : drain_row_s;
    end
  end

  // Sequencer next state; FINISH holds off a new start for the cycle that carries done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    row_d   = row_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPUTE;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == LAST_COMPUTE) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_END) begin
          state_d = ST_FINISH;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          valid_d = 1'b1;
          row_d   = drain_row_s;
          idx_d   = IDX_W'(cnt_q);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign result_row     = row_q;
  assign result_row_idx = idx_q;
  assign done           = done_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Bench for systolic_mac_array: table of pinned C values, random products against a
// plain matrix-multiply model, plus hand sequences for busy-start, reset and back-to-back.
module tb_systolic_mac_array;

  localparam int N    = 8;
  localparam int D    = 8;
  localparam int ACC  = 24;
  localparam int IDXW = 4;
  localparam int CW   = 200;

`ifdef SIGNED_MAC_EN
  localparam logic [ACC-1:0] EXP_SAT = 24'd8;
  localparam logic [ACC-1:0] EXP_NEG = 24'hFFFFFF;
`else
  localparam logic [ACC-1:0] EXP_SAT = 24'd520200;
  localparam logic [ACC-1:0] EXP_NEG = 24'd255;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [D*N-1:0]   left_in;
  logic [D*N-1:0]   top_in;
  logic             busy;
  logic             result_valid;
  logic [ACC*N-1:0] result_row;
  logic [IDXW-1:0]  result_row_idx;
  logic             done;

  systolic_mac_array #(.DATA_SIZE(D), .MAC_WIDTH(N), .ACC_SIZE(ACC), .IDX_W(IDXW)) dut (
    .clock(clock), .reset(reset), .start(start), .left_in(left_in), .top_in(top_in),
    .busy(busy), .result_valid(result_valid), .result_row(result_row),
    .result_row_idx(result_row_idx), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int             a_mode;
    int             b_mode;
    bit             pinned;
    int             row;
    int             col;
    logic [ACC-1:0] exp_val;
  } vec_t;

  int             errors = 0;
  int             checks = 0;
  int             valid_seen;
  int             done_seen;
  logic [D-1:0]   mat_a [N][N];
  logic [D-1:0]   mat_b [N][N];
  logic [ACC-1:0] exp_c [N][N];
  logic [ACC-1:0] got_c [N][N];
  vec_t           vecs [7];

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [D-1:0] pattern(input int mode, input int r, input int c);
    case (mode)
      0:       return (r == c) ? 8'd1 : 8'd0;
      1:       return 8'd255;
      2:       return 8'd1;
      3:       return 8'(8 * r + c);
      4:       return 8'(r + c);
      5:       return 8'($urandom_range(0, 255));
      default: return 8'd0;
    endcase
  endfunction

  task automatic fill(input int am, input int bm);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[r][c] = pattern(am, r, c);
        mat_b[r][c] = pattern(bm, r, c);
      end
  endtask

  function automatic int sval(input logic [D-1:0] v);
`ifdef SIGNED_MAC_EN
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
`else
    return int'(v);
`endif
  endfunction

  task automatic compute_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += sval(mat_a[i][k]) * sval(mat_b[k][j]);
        exp_c[i][j] = ACC'(s);
      end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compute cycle c: row lane i carries A[i][c-i], column lane j carries B[c-j][j].
  task automatic drive_lanes(input int c);
    for (int l = 0; l < N; l++) begin
      if (c - l >= 0 && c - l < N) begin
        left_in[l*D +: D] = mat_a[l][c-l];
        top_in[l*D +: D]  = mat_b[c-l][l];
      end else begin
        left_in[l*D +: D] = 8'd0;
        top_in[l*D +: D]  = 8'd0;
      end
    end
  endtask

  // k counts edges after the accepted start edge; returns on the done cycle.
  task automatic run_product(input bit pre_started, input bit noisy);
    logic [2:0]       exp_ctrl;
    logic [ACC*N-1:0] exp_row;
    compute_model();
    valid_seen = 0;
    done_seen  = 0;
    if (!pre_started) begin
      start   = 1'b0;
      left_in = '0;
      top_in  = '0;
      step();
      start = 1'b1;
      step();
    end
    for (int k = 0; k <= 4 * N; k++) begin
      drive_lanes(k);
      start    = noisy && (k == 5 || k == 3 * N + 2 || k == 4 * N - 1);
      exp_ctrl = {k < 4 * N, (k >= 3 * N) && (k < 4 * N), k == 4 * N};
      check("ctrl_busy_valid_done", {busy, result_valid, done}, exp_ctrl);
      if (result_valid) valid_seen++;
      if (done) done_seen++;
      if (exp_ctrl[1]) begin
        for (int j = 0; j < N; j++) begin
          exp_row[j*ACC +: ACC] = exp_c[k-3*N][j];
          got_c[k-3*N][j]       = result_row[j*ACC +: ACC];
        end
        check("row_idx", result_row_idx, IDXW'(k - 3 * N));
        check("row_data", result_row, exp_row);
      end
      if (k < 4 * N) step();
    end
    start = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{0, 3, 1'b1, 3, 0, 24'd24};
    vecs[1] = '{0, 3, 1'b1, 3, 7, 24'd31};
    vecs[2] = '{1, 1, 1'b1, 5, 2, EXP_SAT};
    vecs[3] = '{2, 2, 1'b1, 0, 0, 24'd8};
    vecs[4] = '{1, 0, 1'b1, 4, 4, EXP_NEG};
    vecs[5] = '{4, 2, 1'b1, 7, 0, 24'd84};
    vecs[6] = '{5, 5, 1'b0, 0, 0, 24'd0};

    reset   = 1'b1;
    start   = 1'b0;
    left_in = '0;
    top_in  = '0;
    #12;
    check("reset_state", {busy, result_valid, done, result_row_idx, result_row}, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].a_mode, vecs[v].b_mode);
      run_product(1'b0, 1'b0);
      if (vecs[v].pinned) check("table_point", got_c[vecs[v].row][vecs[v].col], vecs[v].exp_val);
    end

    for (int r = 0; r < 3; r++) begin
      fill(5, 5);
      run_product(1'b0, 1'b0);
    end

    // Starts while busy must not restart or queue a product.
    fill(5, 5);
    run_product(1'b0, 1'b1);
    check("busy_start_valid_count", valid_seen, N);
    check("busy_start_done_count", done_seen, 1);

    // Start held from the done cycle: ignored there, taken one edge later.
    fill(5, 5);
    start = 1'b1;
    step();
    check("b2b_ignored_on_done", busy, 1'b0);
    step();
    check("b2b_accepted", busy, 1'b1);
    run_product(1'b1, 1'b0);

    // Asynchronous reset at compute cycle 10, then a fresh all-ones product.
    fill(5, 5);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_lanes(c);
      step();
    end
    drive_lanes(10);
    check("busy_before_reset", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_outputs", {busy, result_valid, done, result_row_idx, result_row}, '0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    left_in = '0;
    top_in  = '0;
    fill(2, 2);
    run_product(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (got_c[i][j] !== 24'd8) bad++;
    check("no_stale_after_reset", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
